// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe turn sequencer, board logic and debug display.
package ttt_pkg;

    localparam int unsigned StateWidth = 3;

    // Fixed state encoding; other blocks decode these values directly.
    typedef enum logic [StateWidth-1:0] {
        Idle   = 3'd0,
        P1Move = 3'd1,
        WaitP2 = 3'd2,
        P2Move = 3'd3,
        Done   = 3'd4
    } ttt_state_e;

    localparam logic [StateWidth-1:0] StIdleEnc   = 3'd0;
    localparam logic [StateWidth-1:0] StP1MoveEnc = 3'd1;
    localparam logic [StateWidth-1:0] StWaitP2Enc = 3'd2;
    localparam logic [StateWidth-1:0] StP2MoveEnc = 3'd3;
    localparam logic [StateWidth-1:0] StDoneEnc   = 3'd4;

    // True in the terminal state, where every input except reset is ignored.
    function automatic logic is_terminal(input ttt_state_e st);
        return st == Done;
    endfunction

endpackage

// File: rtl/ttt_turn_fsm.sv
// Turn sequencer: alternates move strobes between two players, re-arms a player
// after an illegal move, and freezes once the game is won or the board is full.
module ttt_turn_fsm
    import ttt_pkg::*;
(
    input  logic clk,
    input  logic reset,     // synchronous, active-low
    input  logic play1,
    input  logic play2,
    input  logic ill_move,
    input  logic no_space,
    input  logic win,
    output logic p1_play,
    output logic p2_play
);

    ttt_state_e state_q, state_d;

    // Next-state: game-over conditions outrank every per-state rule.
    always_comb begin
        state_d = state_q;
        if (!is_terminal(state_q) && (win || no_space)) begin
            state_d = Done;
        end else begin
            case (state_q)
                Idle:    if (play1) state_d = P1Move;
                P1Move:  state_d = ill_move ? Idle : WaitP2;
                WaitP2:  if (play2) state_d = P2Move;
                P2Move:  state_d = ill_move ? WaitP2 : Idle;
                Done:    state_d = Done;
                default: state_d = Idle;
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore outputs: one-cycle write strobes decoded from the state register.
    assign p1_play = (state_q == P1Move);
    assign p2_play = (state_q == P2Move);

endmodule

// File: tb/tb_ttt_turn_fsm.sv
// Directed bench for ttt_turn_fsm; each check compares the {p1_play, p2_play} pair.
module tb_ttt_turn_fsm;

    logic clk = 1'b0;
    logic reset, play1, play2, ill_move, no_space, win;
    logic p1_play, p2_play;

    int checks = 0;
    int errors = 0;

    ttt_turn_fsm dut (
        .clk      (clk),
        .reset    (reset),
        .play1    (play1),
        .play2    (play2),
        .ill_move (ill_move),
        .no_space (no_space),
        .win      (win),
        .p1_play  (p1_play),
        .p2_play  (p2_play)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        play1 = 0; play2 = 0; ill_move = 0; no_space = 0; win = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 0;
        step();
        reset = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0; play1 = 1;
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00", {p1_play, p2_play});
        end
        reset = 1;
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release_p1: got %b want 10", {p1_play, p2_play});
        end
        play1 = 0;
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b00) begin
            errors++;
            $display("FAIL reset_p1_one_cycle: got %b want 00", {p1_play, p2_play});
        end
    endtask

    task automatic test_normal_turn();
        do_reset();
        play1 = 1;
        step();
        play1 = 0;
        step();                        // now WAIT_P2
        play2 = 1;
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b01) begin
            errors++;
            $display("FAIL turn_p2_strobe: got %b want 01", {p1_play, p2_play});
        end
        play2 = 0;
        step();                        // back to IDLE
        checks++;
        if ({p1_play, p2_play} !== 2'b00) begin
            errors++;
            $display("FAIL turn_p2_one_cycle: got %b want 00", {p1_play, p2_play});
        end
        play1 = 1;
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b10) begin
            errors++;
            $display("FAIL turn_back_to_p1: got %b want 10", {p1_play, p2_play});
        end
        play1 = 0;
    endtask

    task automatic test_illegal_move();
        do_reset();
        play1 = 1;
        step();                        // P1_MOVE
        play1 = 0; ill_move = 1;
        step();                        // back to IDLE
        checks++;
        if ({p1_play, p2_play} !== 2'b00) begin
            errors++;
            $display("FAIL ill_p1_no_p2: got %b want 00", {p1_play, p2_play});
        end
        ill_move = 0; play2 = 1;
        step();                        // IDLE ignores play2
        checks++;
        if ({p1_play, p2_play} !== 2'b00) begin
            errors++;
            $display("FAIL ill_p1_idle_ignores_p2: got %b want 00", {p1_play, p2_play});
        end
        play2 = 0; play1 = 1;
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b10) begin
            errors++;
            $display("FAIL ill_p1_retry: got %b want 10", {p1_play, p2_play});
        end
        play1 = 0;
        step();                        // WAIT_P2
        play2 = 1;
        step();                        // P2_MOVE
        play2 = 0; ill_move = 1;
        step();                        // back to WAIT_P2
        checks++;
        if ({p1_play, p2_play} !== 2'b00) begin
            errors++;
            $display("FAIL ill_p2_return: got %b want 00", {p1_play, p2_play});
        end
        ill_move = 0; play1 = 1;
        step();                        // WAIT_P2 ignores play1
        checks++;
        if ({p1_play, p2_play} !== 2'b00) begin
            errors++;
            $display("FAIL ill_p2_wait_ignores_p1: got %b want 00", {p1_play, p2_play});
        end
        play1 = 0; play2 = 1;
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b01) begin
            errors++;
            $display("FAIL ill_p2_retry: got %b want 01", {p1_play, p2_play});
        end
        play2 = 0;
    endtask

    task automatic test_held_button();
        logic [1:0] exp_ill [4];
        logic [1:0] exp_ok  [3];
        exp_ill = '{2'b10, 2'b00, 2'b10, 2'b00};
        exp_ok  = '{2'b10, 2'b00, 2'b00};
        // Held play1 with ill_move held: P1_MOVE every second cycle.
        do_reset();
        play1 = 1; ill_move = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({p1_play, p2_play} !== exp_ill[i]) begin
                errors++;
                $display("FAIL held_ill[%0d]: got %b want %b", i, {p1_play, p2_play}, exp_ill[i]);
            end
        end
        // Held play1 with legal moves: stalls in WAIT_P2.
        do_reset();
        play1 = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({p1_play, p2_play} !== exp_ok[i]) begin
                errors++;
                $display("FAIL held_ok[%0d]: got %b want %b", i, {p1_play, p2_play}, exp_ok[i]);
            end
        end
        play1 = 0;
    endtask

    task automatic test_termination();
        do_reset();
        play1 = 1;
        step();
        play1 = 0;
        step();                        // WAIT_P2
        no_space = 1;
        step();                        // DONE
        no_space = 0;
        for (int i = 0; i < 6; i++) begin
            play1 = i[0]; play2 = ~i[0]; ill_move = i[1];
            step();
            checks++;
            if ({p1_play, p2_play} !== 2'b00) begin
                errors++;
                $display("FAIL done_frozen[%0d]: got %b want 00", i, {p1_play, p2_play});
            end
        end
        // win in IDLE wins over play1.
        do_reset();
        win = 1; play1 = 1;
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b00) begin
            errors++;
            $display("FAIL win_idle: got %b want 00", {p1_play, p2_play});
        end
        win = 0;
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b00) begin
            errors++;
            $display("FAIL win_idle_hold: got %b want 00", {p1_play, p2_play});
        end
        // Reset recovers from DONE.
        do_reset();
        play1 = 1;
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b10) begin
            errors++;
            $display("FAIL done_reset_recover: got %b want 10", {p1_play, p2_play});
        end
        play1 = 0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        play1 = 1;
        step();
        play1 = 0;
        step();
        play2 = 1;
        step();                        // P2_MOVE
        reset = 0;
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: got %b want 00", {p1_play, p2_play});
        end
        reset = 1; play2 = 0; play1 = 1;
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b10) begin
            errors++;
            $display("FAIL mid_reset_idle: got %b want 10", {p1_play, p2_play});
        end
        play1 = 0;
    endtask

    task automatic test_conflict();
        do_reset();
        play1 = 1; play2 = 1;
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b10) begin
            errors++;
            $display("FAIL both_buttons: got %b want 10", {p1_play, p2_play});
        end
        play1 = 0; play2 = 0; win = 1; ill_move = 1;
        step();                        // win outranks ill_move -> DONE
        checks++;
        if ({p1_play, p2_play} !== 2'b00) begin
            errors++;
            $display("FAIL win_over_ill: got %b want 00", {p1_play, p2_play});
        end
        win = 0; ill_move = 0; play1 = 1;
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b00) begin
            errors++;
            $display("FAIL win_over_ill_p1: got %b want 00", {p1_play, p2_play});
        end
        play1 = 0; play2 = 1;
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b00) begin
            errors++;
            $display("FAIL win_over_ill_p2: got %b want 00", {p1_play, p2_play});
        end
        play2 = 0;
        // win during P2_MOVE with ill_move also goes to DONE.
        do_reset();
        play1 = 1;
        step();
        play1 = 0;
        step();
        play2 = 1;
        step();                        // P2_MOVE
        win = 1; ill_move = 1;
        step();
        win = 0; ill_move = 0;         // play2 still held
        step();
        checks++;
        if ({p1_play, p2_play} !== 2'b00) begin
            errors++;
            $display("FAIL win_in_p2: got %b want 00", {p1_play, p2_play});
        end
        play2 = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        test_reset();
        test_normal_turn();
        test_illegal_move();
        test_held_button();
        test_termination();
        test_mid_reset();
        test_conflict();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
